// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the data-memory load/store unit.
//   DMEM_SIZE_*  : encodings of the req_size field
//   lsu_state_e  : LSU control states (ST_IDLE / ST_WAIT / ST_RESP)
package mips_pkg;

  localparam logic [1:0] DMEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] DMEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] DMEM_SIZE_WORD = 2'b10;
  localparam logic [1:0] DMEM_SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Alignment fault for a given access size and the two low address bits.
  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      DMEM_SIZE_BYTE: bad = 1'b0;
      DMEM_SIZE_HALF: bad = lo[0];
      DMEM_SIZE_WORD: bad = (lo != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane steering for sub-word access.
//   size, addr_lo, sign_ext : access descriptor (addr_lo = byte address bits [1:0])
//   wdata                   : store data, sub-word value in the low bits
//   rword                   : full 32-bit word read from the array
//   byte_en                 : byte lanes written by a store
//   wdata_lane              : store data replicated onto every lane
//   rdata_ext               : selected lane(s) zero/sign extended to 32 bits
module lsu_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane 0 of the shifted word is the addressed byte.
  assign rshift = rword >> {addr_lo, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = 32'h0;
    case (size)
      DMEM_SIZE_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      DMEM_SIZE_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      DMEM_SIZE_WORD: begin
        byte_en    = 4'b1111;
        rdata_ext  = rword;
      end
      default: begin
        byte_en    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/d_mem_lsu.sv
// d_mem_lsu: load/store unit with a wait-stated data memory array.
//   clock, reset (async, active low)
//   req_valid/req_ready handshake; req_write, req_size, req_signed, req_addr, req_wdata
//   rsp_valid (one-cycle pulse), rsp_rdata (extended load data), rsp_err
//   busy = ~req_ready (core stall)
// Build option: define DMEM_BYTE_LANE_EN for byte/half accesses; otherwise every
// access is a word access and req_size/req_signed are ignored.
module d_mem_lsu
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        idle, accept, commit;
  logic        cur_write, cur_err, range_err, align_err;
  logic [31:0] cur_addr, cur_wdata, off;
  logic [AW-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane, rdata_ext;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword_q;

  assign idle   = (state_q == ST_IDLE);
  assign accept = req_valid & idle;

  // In IDLE the live request is decoded (an accept may commit at once);
  // afterwards the latched copy is used.
  assign cur_addr  = idle ? req_addr  : addr_q;
  assign cur_write = idle ? req_write : write_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;

  assign off       = cur_addr - ADDR_BASE;
  assign idx       = off[AW+1:2];
  assign range_err = (cur_addr < ADDR_BASE) || (off[31:2] >= DEPTH_LIM);

`ifdef DMEM_BYTE_LANE_EN
  logic [1:0] size_q, size_d, cur_size;
  logic       signed_q, signed_d, cur_signed;

  assign cur_size   = idle ? req_size   : size_q;
  assign cur_signed = idle ? req_signed : signed_q;
  assign align_err  = dmem_misaligned(cur_size, off[1:0]);

  lsu_lane_align u_lane_align (
    .size       (cur_size),
    .addr_lo    (off[1:0]),
    .sign_ext   (cur_signed),
    .wdata      (cur_wdata),
    .rword      (rword_q),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      size_q   <= DMEM_SIZE_BYTE;
      signed_q <= 1'b0;
    end else begin
      size_q   <= size_d;
      signed_q <= signed_d;
    end
  end

  always_comb begin
    size_d   = size_q;
    signed_d = signed_q;
    if (accept) begin
      size_d   = req_size;
      signed_d = req_signed;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{req_size, req_signed};
  assign align_err  = (off[1:0] != 2'b00);
  assign byte_en    = 4'b1111;
  assign wdata_lane = cur_wdata;
  assign rdata_ext  = rword_q;
`endif

  assign cur_err = range_err | align_err;

  // Array access edge: accept edge with no wait states, else last WAIT cycle.
  // Gated by reset so an aborted store can never land while reset is low.
  assign commit = reset & ~cur_err &
                  ((accept && (WAIT_STATES == 0)) || (state_q == ST_WAIT && cnt_q == 4'd0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (cur_err || (WAIT_STATES == 0)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Array has no reset; stores touch only enabled lanes, loads register the word.
  always_ff @(posedge clock) begin
    if (commit) begin
      if (cur_write) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end else begin
        rword_q <= mem[idx];
      end
    end
  end

  assign req_ready = idle;
  assign busy      = ~idle;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & cur_err;
  assign rsp_rdata = (rsp_valid && !cur_err && !cur_write) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_d_mem_lsu.sv
module tb_d_mem_lsu;

  localparam int          DEPTH = 256;
  localparam int          WAIT  = 2;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  always #5 clock = ~clock;

  d_mem_lsu #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WAIT),
    .ADDR_BASE   (BASE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  logic [7:0] mem_b [longint unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory is a plain byte map, accesses are size-byte runs.
  function automatic void model(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    longint unsigned a, v;
    int nb;
    a = addr;
`ifdef DMEM_BYTE_LANE_EN
    case (size)
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: nb = 0;
    endcase
`else
    nb = 4;
`endif
    err = (nb == 0) || (a < BASE) || (((a - BASE) / 4) >= DEPTH);
    if (!err && (a % nb) != 0) err = 1'b1;
    rd = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mem_b[a + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (longint'(mem_b[a + i]) << (8 * i));
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
        rd = v[31:0];
      end
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      @(negedge clock);
      check("busy_vs_ready", {31'h0, busy}, {31'h0, ~req_ready});
      if (rsp_valid) begin
        if (prev_valid) check("rsp_pulse_width", 32'd2, 32'd1);
        check("ready_low_in_resp", {31'h0, req_ready}, 32'h0);
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
          check({e.tag, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
          check({e.tag, "_latency"}, 32'(cyc - e.acc_cyc + 1), e.err ? 32'd1 : 32'(WAIT + 1));
          $display("txn %s rdata=0x%08h err=%0b latency=%0d", e.tag, rsp_rdata, rsp_err,
                   cyc - e.acc_cyc + 1);
        end
      end else if (sb.size() != 0 && (cyc - sb[0].acc_cyc) > WAIT + 4) begin
        e = sb.pop_front();
        check({e.tag, "_timeout"}, 32'd0, 32'd1);
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (req_ready !== 1'b1) begin
      if (guard > 50) begin
        check("ready_stall", 32'd0, 32'd1);
        break;
      end
      guard++;
      // Requester keeps req_valid up with churning fields; DUT must ignore them.
      if (req_valid) begin
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit has_exp, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
    exp_t e;
    logic [31:0] m_rd;
    logic m_err;
    wait_ready();
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clock);
    #1;
    model(wr, size, sgn, addr, wdata, m_rd, m_err);
    e.rdata   = has_exp ? exp_rd : m_rd;
    e.err     = has_exp ? exp_err : m_err;
    e.acc_cyc = cyc;
    e.tag     = tag;
    sb.push_back(e);
    if ($urandom_range(0, 1) == 1) begin
      req_addr  = $urandom;
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int r, guard;

    #1 reset = 1'b0;
    #1;
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_err", {31'h0, rsp_err}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;

    // Preload every word the random phase can touch.
    for (int w = 0; w < 32; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0, 0, 1'b0, "init");
    issue(1'b1, 2'b10, 1'b0, 32'((DEPTH - 1) * 4), $urandom, 1'b0, 0, 1'b0, "init_last");

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, "sw_10");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, "lw_10");
`ifdef DMEM_BYTE_LANE_EN
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b1, 32'h0, 1'b0, "sw_20");
    issue(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, "lb_23");
    issue(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1'b1, 32'h000000FF, 1'b0, "lbu_22");
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, "lh_22");
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b1, 32'h0, 1'b0, "sb_21");
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h80FFAA01, 1'b0, "lw_20");
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, "rsvd_size");
`else
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 32'h0, 1'b1, "lb_21_wordonly");
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 1'b1, "lw_12_misal");
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, 1'b1, 32'h0, 1'b1, "sw_12_misal");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, "lw_10_unchanged");
    issue(1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h1, 1'b1, 32'h0, 1'b1, "sw_oob");

    // Abort a store by reset while it sits in WAIT.
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, "sw_40_zero");
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h40;
    req_wdata = 32'h12345678;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("busy_in_wait", {31'h0, busy}, 32'h1);
    @(negedge clock) reset = 1'b0;
    #1;
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_rdata", rsp_rdata, 32'h0);
    check("abort_err", {31'h0, rsp_err}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, "lw_40_after_abort");

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16)      a = 32'($urandom_range(0, 127));
      else if (r < 18) a = 32'((DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      else if (r == 18) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
      else             a = $urandom | 32'hF000_0000;
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 0, 1'b0, "rnd");
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end

    req_valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clock);
      guard++;
    end
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
